// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multiplexed hex display driver.
// Segment patterns are ordered {g,f,e,d,c,b,a} and are active-low.
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-segment decoder with a blank override.
module hex7seg_dec
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_scan_display.sv
// Shows one of NUM_CH counter values on a DIGITS-digit multiplexed 7-segment display,
// with manual/auto channel selection, frame-aligned snapshots, freeze and zero blanking.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  VAL_W        = 18,
  parameter int unsigned  DIGITS       = 8,
  parameter int unsigned  REFRESH_DIV  = 100000,
  parameter int unsigned  DWELL_FRAMES = 500,
  parameter int unsigned  LZ_BLANK     = 1,
  localparam int unsigned CH_W         = clog2_safe(NUM_CH)
) (
  input  logic                    clk_100MHz_i,
  input  logic                    rst_n,
  input  logic [NUM_CH*VAL_W-1:0] cnt_vals_i,
  input  logic                    auto_i,
  input  logic [CH_W-1:0]         ch_sel_i,
  input  logic                    freeze_i,
  output logic [6:0]              HEX_o,
  output logic                    DP_o,
  output logic [DIGITS-1:0]       AN_o,
  output logic [CH_W-1:0]         ch_o
);

  localparam int unsigned PRESC_W = clog2_safe(REFRESH_DIV);
  localparam int unsigned IDX_W   = clog2_safe(DIGITS);
  localparam int unsigned DWELL_W = clog2_safe(DWELL_FRAMES);
  localparam int unsigned WORD_W  = 4 * DIGITS;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [VAL_W-1:0]   snap_q, snap_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         hex_q, hex_d;
  logic               dp_q, dp_d;

  logic               tick;
  logic               frame_end;
  logic [WORD_W-1:0]  word;
  logic [DIGITS-1:0]  upper_zero;
  logic [3:0]         nibble;
  logic               blank;
  logic [6:0]         seg;

  assign tick      = (presc_q == PRESC_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Channel, dwell and snapshot move only together at a frame boundary, so a frame never
  // mixes digits from two values; the snapshot follows the channel chosen in that same cycle.
  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    if (frame_end && !freeze_i) begin
      if (auto_i) begin
        if (32'(dwell_q) == DWELL_FRAMES - 1) begin
          dwell_d = '0;
          ch_d    = (32'(ch_q) >= NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end else begin
        dwell_d = '0;
        ch_d    = (32'(ch_sel_i) >= NUM_CH) ? CH_W'(NUM_CH - 1) : ch_sel_i;
      end
      snap_d = cnt_vals_i[32'(ch_d) * VAL_W +: VAL_W];
    end
  end

  if (VAL_W >= WORD_W) begin : g_word_msb
    assign word = snap_q[VAL_W-1 -: WORD_W];
  end else begin : g_word_ext
    assign word = {{(WORD_W - VAL_W){1'b0}}, snap_q};
  end

  // upper_zero[i]: nibbles DIGITS-1..i are all zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      upper_zero[i] = ((word >> (4 * i)) == '0);
    end
  end

  assign nibble = word[32'(idx_q) * 4 +: 4];
  assign blank  = (LZ_BLANK != 0) && (idx_q != '0) && upper_zero[idx_q];

  hex7seg_dec u_dec (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (seg)
  );

  always_comb begin
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    hex_d       = seg;
    dp_d        = !(32'(idx_q) == (32'(ch_q) % DIGITS));
  end

  always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      ch_q    <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      hex_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      ch_q    <= ch_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
    end
  end

  assign AN_o  = an_q;
  assign HEX_o = hex_q;
  assign DP_o  = dp_q;
  assign ch_o  = ch_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display: directed phases plus random traffic, compared
// every cycle against a slot/frame-level reference model.
module tb_hex_scan_display;

  localparam int unsigned R   = 4;
  localparam int unsigned D   = 4;
  localparam int unsigned VW  = 16;
  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 2;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [VW-1:0]     vals [NCH];
  logic [NCH*VW-1:0] cnt_vals;
  logic              auto_m = 1'b0;
  logic [1:0]        ch_sel = 2'd0;
  logic              freeze = 1'b0;
  logic [6:0]        hex;
  logic              dp;
  logic [D-1:0]      an;
  logic [1:0]        ch;

  int          n;
  int          errors = 0;
  int          checks = 0;
  int          m_ch;
  int          m_dwell;
  logic [15:0] m_snap;

  assign cnt_vals = {vals[2], vals[1], vals[0]};

  always #5 clk = ~clk;

  hex_scan_display #(
    .NUM_CH       (NCH),
    .VAL_W        (VW),
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .DWELL_FRAMES (DW),
    .LZ_BLANK     (1)
  ) dut (
    .clk_100MHz_i (clk),
    .rst_n        (rst_n),
    .cnt_vals_i   (cnt_vals),
    .auto_i       (auto_m),
    .ch_sel_i     (ch_sel),
    .freeze_i     (freeze),
    .HEX_o        (hex),
    .DP_o         (dp),
    .AN_o         (an),
    .ch_o         (ch)
  );

  function automatic logic [6:0] exp_hex(input logic [15:0] snap, input int d);
    logic [15:0] upper;
    upper = snap >> (4 * d);
    if (d > 0 && upper == 16'h0) return 7'h7F;
    return SEG_REF[upper[3:0]];
  endfunction

  function automatic logic [15:0] rand_val();
    return 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
  endfunction

  task automatic check_outs(input logic [3:0] e_an, input logic [6:0] e_hex, input logic e_dp,
                            input logic [1:0] e_ch, input string tag);
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL %s AN_o: got %h want %h (n=%0d)", tag, an, e_an, n);
    end
    checks++;
    assert (hex === e_hex) else begin
      errors++; $error("FAIL %s HEX_o: got %h want %h (n=%0d)", tag, hex, e_hex, n);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++; $error("FAIL %s DP_o: got %b want %b (n=%0d)", tag, dp, e_dp, n);
    end
    checks++;
    assert (ch === e_ch) else begin
      errors++; $error("FAIL %s ch_o: got %0d want %0d (n=%0d)", tag, ch, e_ch, n);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    m_ch    = 0;
    m_dwell = 0;
    m_snap  = 16'h0;
  endtask

  // One clock: apply the frame-boundary rules to the model, then compare at the falling edge.
  task automatic step(input string tag);
    logic [15:0] shown_snap;
    int          shown_ch;
    int          d;
    @(posedge clk);
    n++;
    shown_snap = m_snap;
    shown_ch   = m_ch;
    if (n % int'(R * D) == 0 && !freeze) begin
      if (auto_m) begin
        if (m_dwell == int'(DW) - 1) begin
          m_dwell = 0;
          m_ch    = (m_ch + 1) % int'(NCH);
        end else begin
          m_dwell++;
        end
      end else begin
        m_dwell = 0;
        m_ch    = (int'(ch_sel) >= int'(NCH)) ? int'(NCH) - 1 : int'(ch_sel);
      end
      m_snap = vals[m_ch];
    end
    @(negedge clk);
    d = ((n - 1) / int'(R)) % int'(D);
    check_outs(~(4'b0001 << d), exp_hex(shown_snap, d), (d == shown_ch % int'(D)) ? 1'b0 : 1'b1,
               2'(m_ch), tag);
  endtask

  task automatic run_edges(input int k, input string tag);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic check_reset(input string tag);
    check_outs(4'hF, 7'h7F, 1'b1, 2'd0, tag);
  endtask

  initial begin
    vals[0] = rand_val();
    vals[1] = 16'h0A3F;
    vals[2] = rand_val();
    ch_sel  = 2'd1;

    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    model_reset();

    // Manual channel 1 showing 0A3F
    run_edges(2 * R * D, "manual");
    checks++;
    assert (ch === 2'd1) else begin
      errors++; $error("FAIL manual_ch: got %0d want 1", ch);
    end

    // Value changes mid-frame; current frame must stay intact
    run_edges(8, "midframe");
    vals[1] = 16'h1234;
    run_edges(2 * R * D, "midframe");

    // Freeze across three frames, then release
    vals[1] = 16'hBEEF;
    freeze  = 1'b1;
    run_edges(3 * R * D, "freeze");
    freeze = 1'b0;
    run_edges(2 * R * D, "unfreeze");

    // Auto rotation with fresh values each frame
    auto_m = 1'b1;
    for (int f = 0; f < 8; f++) begin
      vals[f % 3] = rand_val();
      run_edges(R * D, "auto");
    end

    // Out-of-range manual select clamps to the last channel
    auto_m  = 1'b0;
    ch_sel  = 2'd3;
    vals[2] = 16'h0000;
    run_edges(2 * R * D, "clamp");
    checks++;
    assert (ch === 2'd2) else begin
      errors++; $error("FAIL clamp_ch: got %0d want 2", ch);
    end

    // Random traffic with inputs changing at arbitrary cycles
    for (int e = 0; e < 12 * int'(R * D); e++) begin
      if ($urandom_range(0, 7) == 0) auto_m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ch_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) vals[$urandom_range(0, 2)] = rand_val();
      step("random");
    end
    freeze = 1'b0;

    // Reset mid-scan
    run_edges(5, "pre_reset");
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    repeat (2) @(negedge clk);
    check_reset("reset_mid");
    rst_n = 1'b1;
    model_reset();
    auto_m = 1'b0;
    ch_sel = 2'd0;
    vals[0] = 16'h00C7;
    run_edges(2 * R * D, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
